// File: rtl/lsu_dmem_master_pkg.sv
// Shared types and encodings for the load/store data-memory master.
package lsu_dmem_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Stores only exist as B/H/W; the unsigned encodings are load-only.
  function automatic logic req_is_bad(input logic       store,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = (addr_lo != 2'b00);
      F3_BU:   bad = store;
      F3_HU:   bad = store | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_dmem_master_load_extend.sv
// Combinational sign/zero extension of the raw dmem word for loads.
module lsu_dmem_master_load_extend
  import lsu_dmem_master_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        i_funct3,
  input  logic [DATA_W-1:0] i_raw,
  output logic [DATA_W-1:0] o_data
);

  always_comb begin
    o_data = i_raw;
    case (i_funct3)
      F3_B:    o_data = {{(DATA_W-8){i_raw[7]}}, i_raw[7:0]};
      F3_BU:   o_data = {{(DATA_W-8){1'b0}}, i_raw[7:0]};
      F3_H:    o_data = {{(DATA_W-16){i_raw[15]}}, i_raw[15:0]};
      F3_HU:   o_data = {{(DATA_W-16){1'b0}}, i_raw[15:0]};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store unit master for the data-memory port: one request at a time,
// bus handshake with optional timeout, extended load data back to writeback.
//
// state | meaning
// IDLE  | ready for a request from the pipeline
// BUS   | strobe asserted, waiting for i_dmem_ready or timeout
// RESP  | one-cycle response pulse, bus strobes low
module lsu_dmem_master
  import lsu_dmem_master_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_store,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic              o_dmem_r_enable,
  output logic              o_dmem_w_enable,
  output logic [1:0]        o_dmem_w_size,
  output logic [DATA_W-1:0] o_dmem_w_data,
  input  logic [DATA_W-1:0] i_dmem_r_data,
  input  logic              i_dmem_ready
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_bad;
  logic              w_timeout;
  logic [DATA_W-1:0] w_ext;

  assign w_bad     = req_is_bad(i_req_store, i_req_funct3, i_req_addr[1:0]);
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  lsu_dmem_master_load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .i_funct3 (r_funct3),
    .i_raw    (r_rdata),
    .o_data   (w_ext)
  );

  assign o_dmem_addr   = r_addr;
  assign o_dmem_w_data = r_wdata;

  always_comb begin
    w_next          = r_state;
    o_req_ready     = 1'b0;
    o_busy          = 1'b1;
    o_dmem_r_enable = 1'b0;
    o_dmem_w_enable = 1'b0;
    o_dmem_w_size   = SZ_BYTE;
    o_resp_valid    = 1'b0;
    o_resp_err      = 1'b0;
    o_resp_rdata    = '0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_req_valid) w_next = w_bad ? ST_RESP : ST_BUS;
      end
      ST_BUS: begin
        o_dmem_r_enable = !r_store;
        o_dmem_w_enable = r_store;
        o_dmem_w_size   = r_funct3[1:0];
        if (i_dmem_ready || w_timeout) w_next = ST_RESP;
      end
      ST_RESP: begin
        o_resp_valid = 1'b1;
        o_resp_err   = r_err;
        // Stores and failed accesses return zero data.
        if (!r_err && !r_store) o_resp_rdata = w_ext;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_store  <= 1'b0;
      r_funct3 <= 3'b000;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (i_req_valid) begin
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
            r_store  <= i_req_store;
            r_funct3 <= i_req_funct3;
            r_err    <= w_bad;
          end
        end
        ST_BUS: begin
          r_cnt <= r_cnt + 1'b1;
          if (i_dmem_ready) begin
            r_rdata <= i_dmem_r_data;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
